apb_gpio_v2: RTL and testbench

Parametrised APB GPIO controller, NUM_GPIO pins (1..32).
- Per-pin direction and output, with atomic set/clear output registers.
- Per-pin programmable glitch filter (debounce) on inputs.
- Per-pin sticky write-1-to-clear interrupt status; single level interrupt line.
- Sits on the peripheral APB bus beside the other APB slaves, driving pad muxes and the event/interrupt controller.

---
 rtl/apb_gpio_v2_pkg.sv | 38 +++
 rtl/gpio_debounce.sv | 51 +++++
 rtl/apb_gpio_v2.sv | 200 ++++++++++++++++++++
 tb/tb_apb_gpio_v2.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_gpio_v2_pkg.sv
// Shared definitions for the APB GPIO controller: register indices, interrupt types, read-back helper.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package apb_gpio_v2_pkg;

    // Register word indices, decoded from PADDR[5:2]
    localparam logic [3:0] REG_DIR        = 4'h0;
    localparam logic [3:0] REG_IN         = 4'h1;
    localparam logic [3:0] REG_OUT        = 4'h2;
    localparam logic [3:0] REG_OUTSET     = 4'h3;
    localparam logic [3:0] REG_OUTCLR     = 4'h4;
    localparam logic [3:0] REG_INTEN      = 4'h5;
    localparam logic [3:0] REG_INTTYPE0   = 4'h6;
    localparam logic [3:0] REG_INTTYPE1   = 4'h7;
    localparam logic [3:0] REG_INTSTATUS  = 4'h8;
    localparam logic [3:0] REG_DBEN       = 4'h9;
    localparam logic [3:0] REG_DBTHRESH   = 4'hA;
    localparam logic [3:0] REG_POWEREVENT = 4'hB;

    // First index of the unmapped window (0x30-0x3C)
    localparam logic [3:0] REG_FIRST_UNMAPPED = 4'hC;

    // Interrupt condition, encoded as {INTTYPE1[i], INTTYPE0[i]}
    typedef enum logic [1:0] {
        LEVEL_HI = 2'b00,
        LEVEL_LO = 2'b01,
        RISE     = 2'b10,
        FALL     = 2'b11
    } inttype_e;

    // Clears every bit at or above the pin count so unused pins always read back as 0
    function automatic logic [31:0] zext_pins(input logic [31:0] v, input int unsigned n);
        logic [31:0] mask;
        mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        return v & mask;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One-pin glitch filter: output follows the synchronised input once it has differed for thresh+1 cycles.
// Latency: 1 cycle when disabled, thresh_i+1 cycles of stable difference when enabled.
// Backpressure: none; free-running every cycle.
module gpio_debounce
    import apb_gpio_v2_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             sync_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] thresh_i,
    output logic             filt_o
);

    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next filtered value and run-length counter; a single matching sample restarts the count
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (!en_i) begin
            filt_d = sync_i;
            cnt_d  = '0;
        end else if (sync_i == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == thresh_i) begin
            // Equality compare on purpose: a count already past a freshly lowered threshold wraps around
            filt_d = sync_i;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Filter state flops
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/apb_gpio_v2.sv
// APB GPIO controller: direction/output registers, filtered inputs, sticky interrupts, wake request.
// Latency: zero-wait-state APB; input pin to IN is 3 clocks (DBEN=0), to INTSTATUS 4, to interrupt 5.
// Backpressure: none; PREADY is tied high and every access completes in its access phase.
module apb_gpio_v2
    import apb_gpio_v2_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned NUM_GPIO       = 32,
    parameter int unsigned DB_CNT_W       = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_GPIO-1:0]       gpio_in,
    output logic [NUM_GPIO-1:0]       gpio_in_sync,
    output logic [NUM_GPIO-1:0]       gpio_out,
    output logic [NUM_GPIO-1:0]       gpio_dir,
    output logic                      power_event,
    output logic                      interrupt
);

    // ------------------------------------------------------------------
    // Register and pipeline state
    // ------------------------------------------------------------------
    logic [NUM_GPIO-1:0] dir_q,      dir_d;
    logic [NUM_GPIO-1:0] out_q,      out_d;
    logic [NUM_GPIO-1:0] inten_q,    inten_d;
    logic [NUM_GPIO-1:0] type0_q,    type0_d;
    logic [NUM_GPIO-1:0] type1_q,    type1_d;
    logic [NUM_GPIO-1:0] status_q,   status_d;
    logic [NUM_GPIO-1:0] dben_q,     dben_d;
    logic [DB_CNT_W-1:0] thresh_q,   thresh_d;
    logic [NUM_GPIO-1:0] pwr_mask_q, pwr_mask_d;

    logic [NUM_GPIO-1:0] sync0_q,    sync0_d;
    logic [NUM_GPIO-1:0] sync1_q,    sync1_d;
    logic [NUM_GPIO-1:0] filt_dly_q, filt_dly_d;
    logic                irq_q,      irq_d;
    logic                pwr_q,      pwr_d;

    logic [NUM_GPIO-1:0] filt;
    logic [NUM_GPIO-1:0] int_cond;
    logic [NUM_GPIO-1:0] wdata_pins;
    logic [NUM_GPIO-1:0] w1c_mask;
    logic [3:0]          reg_idx;
    logic                acc_en;
    logic                wr_en;
    logic [31:0]         rdata;
    logic                unused_bits;

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    assign reg_idx    = PADDR[5:2];
    assign acc_en     = PSEL & PENABLE;
    assign wr_en      = acc_en & PWRITE;
    assign wdata_pins = PWDATA[NUM_GPIO-1:0];
    assign w1c_mask   = (wr_en && reg_idx == REG_INTSTATUS) ? wdata_pins : '0;

    assign PREADY  = 1'b1;
    assign PSLVERR = acc_en & (reg_idx >= REG_FIRST_UNMAPPED);

    // Upper address bits and write-data bits above the pin count are intentionally ignored
    assign unused_bits = ^{PADDR, PWDATA};

    // ------------------------------------------------------------------
    // Per-pin glitch filters
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_GPIO; i++) begin : g_db
        gpio_debounce #(
            .CNT_W (DB_CNT_W)
        ) u_db (
            .HCLK     (HCLK),
            .HRESETn  (HRESETn),
            .sync_i   (sync1_q[i]),
            .en_i     (dben_q[i]),
            .thresh_i (thresh_q),
            .filt_o   (filt[i])
        );
    end

    // Per-pin interrupt condition selected by the two type bits
    always_comb begin
        int_cond = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            case (inttype_e'({type1_q[i], type0_q[i]}))
                LEVEL_HI: int_cond[i] = filt[i];
                LEVEL_LO: int_cond[i] = ~filt[i];
                RISE:     int_cond[i] = filt[i] & ~filt_dly_q[i];
                FALL:     int_cond[i] = ~filt[i] & filt_dly_q[i];
                default:  int_cond[i] = 1'b0;
            endcase
        end
    end

    // Register writes, status update and input pipeline next-state
    always_comb begin
        dir_d      = dir_q;
        out_d      = out_q;
        inten_d    = inten_q;
        type0_d    = type0_q;
        type1_d    = type1_q;
        dben_d     = dben_q;
        thresh_d   = thresh_q;
        pwr_mask_d = pwr_mask_q;

        if (wr_en) begin
            case (reg_idx)
                REG_DIR:        dir_d      = wdata_pins;
                REG_OUT:        out_d      = wdata_pins;
                REG_OUTSET:     out_d      = out_q | wdata_pins;
                REG_OUTCLR:     out_d      = out_q & ~wdata_pins;
                REG_INTEN:      inten_d    = wdata_pins;
                REG_INTTYPE0:   type0_d    = wdata_pins;
                REG_INTTYPE1:   type1_d    = wdata_pins;
                REG_DBEN:       dben_d     = wdata_pins;
                REG_DBTHRESH:   thresh_d   = PWDATA[DB_CNT_W-1:0];
                REG_POWEREVENT: pwr_mask_d = wdata_pins;
                default:        ;
            endcase
        end

        // A condition seen this cycle wins over a simultaneous write-1-to-clear
        status_d   = (status_q & ~w1c_mask) | int_cond;

        sync0_d    = gpio_in;
        sync1_d    = sync0_q;
        filt_dly_d = filt;
        irq_d      = |(status_q & inten_q);
        pwr_d      = |(filt & pwr_mask_q);
    end

    // All state flops; reset clears everything, including any access in flight
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dir_q      <= '0;
            out_q      <= '0;
            inten_q    <= '0;
            type0_q    <= '0;
            type1_q    <= '0;
            status_q   <= '0;
            dben_q     <= '0;
            thresh_q   <= '0;
            pwr_mask_q <= '0;
            sync0_q    <= '0;
            sync1_q    <= '0;
            filt_dly_q <= '0;
            irq_q      <= 1'b0;
            pwr_q      <= 1'b0;
        end else begin
            dir_q      <= dir_d;
            out_q      <= out_d;
            inten_q    <= inten_d;
            type0_q    <= type0_d;
            type1_q    <= type1_d;
            status_q   <= status_d;
            dben_q     <= dben_d;
            thresh_q   <= thresh_d;
            pwr_mask_q <= pwr_mask_d;
            sync0_q    <= sync0_d;
            sync1_q    <= sync1_d;
            filt_dly_q <= filt_dly_d;
            irq_q      <= irq_d;
            pwr_q      <= pwr_d;
        end
    end

    // Read mux; write-only and unmapped locations read as 0
    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_DIR:        rdata = zext_pins(32'(dir_q), NUM_GPIO);
            REG_IN:         rdata = zext_pins(32'(filt), NUM_GPIO);
            REG_OUT:        rdata = zext_pins(32'(out_q), NUM_GPIO);
            REG_INTEN:      rdata = zext_pins(32'(inten_q), NUM_GPIO);
            REG_INTTYPE0:   rdata = zext_pins(32'(type0_q), NUM_GPIO);
            REG_INTTYPE1:   rdata = zext_pins(32'(type1_q), NUM_GPIO);
            REG_INTSTATUS:  rdata = zext_pins(32'(status_q), NUM_GPIO);
            REG_DBEN:       rdata = zext_pins(32'(dben_q), NUM_GPIO);
            REG_DBTHRESH:   rdata = 32'(thresh_q);
            REG_POWEREVENT: rdata = zext_pins(32'(pwr_mask_q), NUM_GPIO);
            default:        rdata = '0;
        endcase
    end

    assign PRDATA       = (PSEL && !PWRITE) ? rdata : 32'h0;
    assign gpio_in_sync = filt;
    assign gpio_out     = out_q;
    assign gpio_dir     = dir_q;
    assign interrupt    = irq_q;
    assign power_event  = pwr_q;

endmodule

// File: tb/tb_apb_gpio_v2.sv
module tb_apb_gpio_v2;

    logic        clk = 1'b0;
    logic        hresetn = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pwrite = 1'b0;
    logic        psel32 = 1'b0;
    logic        psel8 = 1'b0;
    logic        penable = 1'b0;

    logic [31:0] prdata32, prdata8;
    logic        pready32, pready8, pslverr32, pslverr8;
    logic [31:0] gpio_in32 = '0, gpio_sync32, gpio_out32, gpio_dir32;
    logic [7:0]  gpio_in8 = '0, gpio_sync8, gpio_out8, gpio_dir8;
    logic        pwr32, pwr8, irq32, irq8;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    apb_gpio_v2 #(.APB_ADDR_WIDTH(12), .NUM_GPIO(32), .DB_CNT_W(8)) dut32 (
        .HCLK(clk), .HRESETn(hresetn), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
        .PSEL(psel32), .PENABLE(penable), .PRDATA(prdata32), .PREADY(pready32), .PSLVERR(pslverr32),
        .gpio_in(gpio_in32), .gpio_in_sync(gpio_sync32), .gpio_out(gpio_out32), .gpio_dir(gpio_dir32),
        .power_event(pwr32), .interrupt(irq32)
    );

    apb_gpio_v2 #(.APB_ADDR_WIDTH(12), .NUM_GPIO(8), .DB_CNT_W(8)) dut8 (
        .HCLK(clk), .HRESETn(hresetn), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
        .PSEL(psel8), .PENABLE(penable), .PRDATA(prdata8), .PREADY(pready8), .PSLVERR(pslverr8),
        .gpio_in(gpio_in8), .gpio_in_sync(gpio_sync8), .gpio_out(gpio_out8), .gpio_dir(gpio_dir8),
        .power_event(pwr8), .interrupt(irq8)
    );

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One full APB transfer; rd/err are sampled mid access phase
    task automatic apb(input bit to8, input logic wr, input logic [5:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
        @(posedge clk); #1;
        paddr   = {6'h0, addr};
        pwrite  = wr;
        pwdata  = wd;
        psel32  = !to8;
        psel8   = to8;
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        rd  = to8 ? prdata8 : prdata32;
        err = to8 ? pslverr8 : pslverr32;
        @(posedge clk); #1;
        psel32  = 1'b0;
        psel8   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic wr32(input logic [5:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        logic        err;
        apb(1'b0, 1'b1, addr, wd, rd, err);
    endtask

    task automatic rd_chk(input bit to8, input logic [5:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] rd;
        logic        err;
        apb(to8, 1'b0, addr, 32'h0, rd, err);
        check(name, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;

        // Table: reset read-back, unmapped window, IN/OUT/OUTSET/OUTCLR, width clipping
        for (int a = 0; a < 12; a++) vecs.push_back('{1'b0, 6'(a * 4), 32'h0, 1'b1, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 6'h30, 32'h0,         1'b1, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 6'h3C, 32'h0,         1'b1, 32'h0,         1'b1});
        vecs.push_back('{1'b1, 6'h34, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1});
        vecs.push_back('{1'b1, 6'h04, 32'h0000_FFFF, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 6'h04, 32'h0,         1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 6'h08, 32'h0000_F0F0, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 6'h0C, 32'h0000_000F, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 6'h10, 32'h0000_00F0, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 6'h08, 32'h0,         1'b1, 32'h0000_F00F, 1'b0});
        vecs.push_back('{1'b0, 6'h0C, 32'h0,         1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 6'h10, 32'h0,         1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 6'h0C, 32'h0,         1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 6'h08, 32'h0,         1'b1, 32'h0000_F00F, 1'b0});
        vecs.push_back('{1'b1, 6'h00, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 6'h00, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{1'b1, 6'h00, 32'h0,         1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 6'h28, 32'h0000_01FF, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 6'h28, 32'h0,         1'b1, 32'h0000_00FF, 1'b0});
        vecs.push_back('{1'b1, 6'h2C, 32'h1234_5678, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 6'h2C, 32'h0,         1'b1, 32'h1234_5678, 1'b0});
        vecs.push_back('{1'b1, 6'h2C, 32'h0,         1'b0, 32'h0,         1'b0});

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_gpio_out", gpio_out32, 32'h0);
        check("rst_gpio_dir", gpio_dir32, 32'h0);
        check("rst_interrupt", 32'(irq32), 32'h0);
        check("rst_power_event", 32'(pwr32), 32'h0);
        check("rst_prdata", prdata32, 32'h0);
        check("rst_pslverr", 32'(pslverr32), 32'h0);
        hresetn = 1'b1;
        check("pready", 32'(pready32), 32'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            apb(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rd@%02h", i, vecs[i].addr), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err@%02h", i, vecs[i].addr), 32'(err), 32'(vecs[i].exp_err));
        end
        check("gpio_out_after_setclr", gpio_out32, 32'h0000_F00F);

        // Rising-edge interrupt on pin 3 (pin 2 also rising type for later)
        wr32(6'h1C, 32'h0000_000C);
        wr32(6'h14, 32'h0000_0008);
        @(posedge clk); #1;
        paddr = 12'h020; pwrite = 1'b0; psel32 = 1'b1; penable = 1'b1;
        gpio_in32[3] = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk); #1;
            check($sformatf("rise_in3_c%0d", cyc), 32'(gpio_sync32[3]), (cyc >= 3) ? 32'h1 : 32'h0);
            check($sformatf("rise_status_c%0d", cyc), prdata32, (cyc >= 4) ? 32'h8 : 32'h0);
            check($sformatf("rise_irq_c%0d", cyc), 32'(irq32), (cyc >= 5) ? 32'h1 : 32'h0);
        end
        psel32 = 1'b0; penable = 1'b0;
        wr32(6'h20, 32'h0000_0008);
        check("w1c_irq_still_1", 32'(irq32), 32'h1);
        @(posedge clk); #1;
        check("w1c_irq_cleared", 32'(irq32), 32'h0);
        rd_chk(1'b0, 6'h20, 32'h0, "w1c_status");

        // Debounce on pin 0, threshold 4
        wr32(6'h24, 32'h0000_0001);
        wr32(6'h28, 32'h0000_0004);
        @(posedge clk); #1;
        gpio_in32[0] = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 3) gpio_in32[0] = 1'b0;
            check($sformatf("glitch_in0_c%0d", cyc), 32'(gpio_sync32[0]), 32'h0);
        end
        rd_chk(1'b0, 6'h20, 32'h0, "glitch_no_status");
        @(posedge clk); #1;
        gpio_in32[0] = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            check($sformatf("pulse_in0_c%0d", cyc), 32'(gpio_sync32[0]), (cyc >= 7) ? 32'h1 : 32'h0);
        end
        rd_chk(1'b0, 6'h04, 32'h0000_0009, "pulse_in_reg");
        gpio_in32[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        wr32(6'h24, 32'h0);
        wr32(6'h20, 32'hFFFF_FFFF);
        rd_chk(1'b0, 6'h20, 32'h0, "clear_all_status");
        rd_chk(1'b0, 6'h04, 32'h0000_0008, "in_after_pulse");

        // Level-low on pin 1 with input held low: W1C cannot clear it
        wr32(6'h18, 32'h0000_0002);
        wr32(6'h14, 32'h0000_0002);
        rd_chk(1'b0, 6'h20, 32'h0000_0002, "lvl_lo_status");
        wr32(6'h20, 32'h0000_0002);
        rd_chk(1'b0, 6'h20, 32'h0000_0002, "lvl_lo_after_w1c");
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(posedge clk); #1;
            check($sformatf("lvl_lo_irq_c%0d", cyc), 32'(irq32), 32'h1);
        end

        // Rising edge on pin 2 lands on the same edge as its W1C
        @(posedge clk); #1;
        gpio_in32[2] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        paddr = 12'h020; pwrite = 1'b1; pwdata = 32'h0000_0004; psel32 = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel32 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        rd_chk(1'b0, 6'h20, 32'h0000_0006, "set_beats_w1c");

        // 8-pin build: clipping and power event
        apb(1'b1, 1'b1, 6'h00, 32'hFFFF_FFFF, rd, err);
        rd_chk(1'b1, 6'h00, 32'h0000_00FF, "n8_dir_clip");
        check("n8_gpio_dir", 32'(gpio_dir8), 32'h0000_00FF);
        apb(1'b1, 1'b0, 6'h30, 32'h0, rd, err);
        check("n8_unmapped_err", 32'(err), 32'h1);
        apb(1'b1, 1'b1, 6'h2C, 32'h0000_0081, rd, err);
        rd_chk(1'b1, 6'h2C, 32'h0000_0081, "n8_pwr_mask");
        @(posedge clk); #1;
        gpio_in8[7] = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clk); #1;
            check($sformatf("n8_pwr_c%0d", cyc), 32'(pwr8), (cyc >= 4) ? 32'h1 : 32'h0);
        end

        // Reset in the middle of an access
        wr32(6'h08, 32'h0000_00FF);
        check("pre_reset_out", gpio_out32, 32'h0000_00FF);
        @(posedge clk); #1;
        paddr = 12'h008; pwrite = 1'b1; pwdata = 32'h0000_000F; psel32 = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        #2;
        hresetn = 1'b0;
        #1;
        check("midrst_out", gpio_out32, 32'h0);
        check("midrst_irq", 32'(irq32), 32'h0);
        check("midrst_pwr8", 32'(pwr8), 32'h0);
        psel32 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
